mmio_uart_tx: RTL

MMIO_UART_TX -- requirements
Module: mmio_uart_tx

---
 rtl/mmio_uart_tx.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a small TX FIFO.
// Registers: TXDATA (+0x0, write pushes a byte), STATUS (+0x4), BAUDDIV (+0x8).
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter logic [15:0] DEFAULT_DIV = 16'd868,
    parameter int          FIFO_DEPTH  = 8            // power of 2, 2..16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        d_we,
    input  logic [3:0]  d_wstrb,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        uart_tx,
    output logic        irq_tx_empty
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] OFF_TXDATA  = 2'd0;
    localparam logic [1:0] OFF_STATUS  = 2'd1;
    localparam logic [1:0] OFF_BAUDDIV = 2'd2;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state_q, state_d;
    logic [7:0]         fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ovf_q;
    logic [15:0]        bauddiv_q;
    logic [15:0]        frame_div;
    logic [15:0]        baud_cnt;
    logic [2:0]         bit_idx;
    logic [7:0]         shreg;
    logic               tx_q;
    logic               irq_q;

    // Address decode: the window is 16 bytes, registers are word-sized.
    logic in_win, sel_tx, sel_status, sel_div;
    assign in_win     = (d_addr[31:4] == BASE_ADDR[31:4]);
    assign sel_tx     = in_win && (d_addr[3:2] == OFF_TXDATA);
    assign sel_status = in_win && (d_addr[3:2] == OFF_STATUS);
    assign sel_div    = in_win && (d_addr[3:2] == OFF_BAUDDIV);

    logic wr_tx, wr_ovf_clr, wr_div;
    assign wr_tx      = d_we && sel_tx && d_wstrb[0];
    assign wr_ovf_clr = d_we && sel_status && d_wstrb[0] && d_wdata[3];
    assign wr_div     = d_we && sel_div;

    // Bus bits this block never looks at.
    logic unused_bus;
    assign unused_bus = ^{d_wstrb[3:2], d_wdata[31:16], d_addr[1:0]};

    logic full, empty, busy, pop, push, ovf_set, baud_last;
    logic [15:0] div_eff;
    assign full      = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty     = (count_q == '0);
    assign busy      = (state_q != IDLE);
    // A push into a full FIFO still fits when the head leaves on the same edge.
    assign push      = wr_tx && (!full || pop);
    assign ovf_set   = wr_tx && full && !pop;
    assign div_eff   = (bauddiv_q == 16'd0) ? 16'd1 : bauddiv_q;
    assign baud_last = (baud_cnt == frame_div - 16'd1);

    // FSM next state and FIFO pop request.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE:  if (!empty) begin
                       pop     = 1'b1;
                       state_d = START;
                   end
            START: if (baud_last) state_d = DATA;
            DATA:  if (baud_last && bit_idx == 3'd7) state_d = STOP;
            STOP:  if (baud_last) begin
                       if (!empty) begin
                           pop     = 1'b1;
                           state_d = START;
                       end else begin
                           state_d = IDLE;
                       end
                   end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FIFO storage; emptiness is defined by the pointers, not by the contents.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately left out of reset; resetting pointers is enough.
        if (push) fifo_mem[wr_ptr] <= d_wdata[7:0];
    end

    // Next FIFO occupancy.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO pointers and count; pointers wrap naturally at the power-of-2 depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count_q <= count_d;
        end
    end

    // Overflow flag; a new overflow wins over a clear on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          ovf_q <= 1'b0;
        else if (ovf_set)    ovf_q <= 1'b1;
        else if (wr_ovf_clr) ovf_q <= 1'b0;
    end

    // BAUDDIV register with per-byte-lane writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bauddiv_q <= DEFAULT_DIV;
        end else if (wr_div) begin
            if (d_wstrb[0]) bauddiv_q[7:0]  <= d_wdata[7:0];
            if (d_wstrb[1]) bauddiv_q[15:8] <= d_wdata[15:8];
        end
    end

    // Bit timing, shift register and serial line; the divisor is frozen per frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg     <= '0;
            frame_div <= 16'd1;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            tx_q      <= 1'b1;
        end else if (pop) begin
            shreg     <= fifo_mem[rd_ptr];
            frame_div <= div_eff;
            baud_cnt  <= '0;
            tx_q      <= 1'b0;
        end else if (state_q == IDLE) begin
            baud_cnt  <= '0;
            tx_q      <= 1'b1;
        end else if (!baud_last) begin
            baud_cnt  <= baud_cnt + 16'd1;
        end else begin
            baud_cnt <= '0;
            case (state_q)
                START: tx_q <= shreg[0];
                DATA: begin
                    bit_idx <= bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        tx_q <= 1'b1;
                    end else begin
                        tx_q  <= shreg[1];
                        shreg <= {1'b0, shreg[7:1]};
                    end
                end
                default: tx_q <= 1'b1;
            endcase
        end
    end

    // Empty interrupt tracks the state the FIFO and FSM are about to enter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) irq_q <= 1'b1;
        else        irq_q <= (count_d == '0) && (state_d == IDLE);
    end

    assign uart_tx      = tx_q;
    assign irq_tx_empty = irq_q;

    // Side-effect-free read mux; anything outside the window reads 0.
    always_comb begin
        d_rdata = '0;
        if (in_win) begin
            case (d_addr[3:2])
                OFF_STATUS:  d_rdata = {23'd0, 5'(count_q), ovf_q, empty, full, busy};
                OFF_BAUDDIV: d_rdata = {16'd0, bauddiv_q};
                default:     d_rdata = '0;
            endcase
        end
    end

endmodule
